// File: rtl/bomberman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bomberman_pkg
//  Description : Shared constants, state encoding and the blast-cross test
//                used by the bomb engine and its arm-length calculator.
//                Contents:
//                  TILE_LOG2, COLS, ROWS  - arena geometry
//                  TILE_W                 - tile-coordinate width
//                  BOMB_RGB, EXPL_RGB     - layer colours
//                  bomb_state_t           - IDLE / ARMED / EXPLODING
//                  in_cross()             - tile-in-blast-cross test
//  Revision    : 1.0 - initial release
// ============================================================================
package bomberman_pkg;

    localparam int          TILE_LOG2 = 5;
    localparam int          COLS      = 15;
    localparam int          ROWS      = 13;
    localparam int          TILE_W    = 5;

    localparam logic [11:0] BOMB_RGB  = 12'h222;
    localparam logic [11:0] EXPL_RGB  = 12'hF80;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_EXPLODING = 2'd2
    } bomb_state_t;

    // True when tile (col,row) lies on the blast cross centred on (cc,cr)
    // with arm lengths l/r/u/d. The centre tile is covered by the row term
    // because every arm length is non-negative. Bounds are evaluated in
    // 11 bits so that col+l and cc+r cannot wrap.
    function automatic logic in_cross(
        input logic [9:0] col,
        input logic [9:0] row,
        input logic [9:0] cc,
        input logic [9:0] cr,
        input logic [9:0] l,
        input logic [9:0] r,
        input logic [9:0] u,
        input logic [9:0] d
    );
        logic [10:0] col_e, row_e, cc_e, cr_e;
        logic        on_row, on_col;
        col_e  = {1'b0, col};
        row_e  = {1'b0, row};
        cc_e   = {1'b0, cc};
        cr_e   = {1'b0, cr};
        on_row = (row == cr) && ((col_e + {1'b0, l}) >= cc_e) && (col_e <= (cc_e + {1'b0, r}));
        on_col = (col == cc) && ((row_e + {1'b0, u}) >= cr_e) && (row_e <= (cr_e + {1'b0, d}));
        return on_row || on_col;
    endfunction

endpackage : bomberman_pkg
`default_nettype wire

// File: rtl/blast_arm_calc.sv
`default_nettype none
// ============================================================================
//  Module      : blast_arm_calc
//  Description : Combinational arm-length calculator for a bomb at
//                (i_bomb_col, i_bomb_row). Each arm is the blast range
//                clamped to the arena border; arms that would run along a
//                pillar row/column (odd index) are forced to zero.
//  Ports       : i_bomb_col/i_bomb_row  bomb tile
//                o_left/o_right/o_up/o_down  arm lengths in tiles
//  Revision    : 1.0 - initial release
// ============================================================================
module blast_arm_calc
    import bomberman_pkg::*;
#(
    parameter int COLS  = 15,
    parameter int ROWS  = 13,
    parameter int RANGE = 2
) (
    input  logic [TILE_W-1:0] i_bomb_col,
    input  logic [TILE_W-1:0] i_bomb_row,
    output logic [TILE_W-1:0] o_left,
    output logic [TILE_W-1:0] o_right,
    output logic [TILE_W-1:0] o_up,
    output logic [TILE_W-1:0] o_down
);

    localparam logic [TILE_W-1:0] C_RANGE   = TILE_W'(RANGE);
    localparam logic [TILE_W-1:0] C_COL_MAX = TILE_W'(COLS - 1);
    localparam logic [TILE_W-1:0] C_ROW_MAX = TILE_W'(ROWS - 1);

    logic [TILE_W-1:0] w_room_right;
    logic [TILE_W-1:0] w_room_down;

    // Distance to the far border; saturates at zero for a tile at or past it.
    assign w_room_right = (i_bomb_col >= C_COL_MAX) ? '0 : (C_COL_MAX - i_bomb_col);
    assign w_room_down  = (i_bomb_row >= C_ROW_MAX) ? '0 : (C_ROW_MAX - i_bomb_row);

    always_comb begin
        o_left  = (i_bomb_col   < C_RANGE) ? i_bomb_col   : C_RANGE;
        o_right = (w_room_right < C_RANGE) ? w_room_right : C_RANGE;
        o_up    = (i_bomb_row   < C_RANGE) ? i_bomb_row   : C_RANGE;
        o_down  = (w_room_down  < C_RANGE) ? w_room_down  : C_RANGE;

        // An odd row is a pillar row: horizontal arms are blocked at once.
        if (i_bomb_row[0]) begin
            o_left  = '0;
            o_right = '0;
        end
        // An odd column is a pillar column: vertical arms are blocked.
        if (i_bomb_col[0]) begin
            o_up    = '0;
            o_down  = '0;
        end
    end

endmodule : blast_arm_calc
`default_nettype wire

// File: rtl/bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_controller
//  Description : Single-bomb placement, fuse and explosion engine. Places a
//                bomb on the player's tile on a rising edge of C, runs the
//                fuse, then shows a clamped, pillar-masked blast cross.
//  Ports       : clk, reset (sync, active-high)
//                C           place-bomb button (level, debounced)
//                b_x, b_y    player sprite top-left, pixels
//                game_over   freezes timers and blocks placement
//                v_x, v_y    current VGA pixel
//                bomb_active / explode_active  FSM status
//                bomb_col / bomb_row           bomb tile
//                player_hit  player tile inside blast (1-cycle latency)
//                bomb_rgb/bomb_on, explosion_rgb/explosion_on  pixel layers
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_controller
    import bomberman_pkg::*;
#(
    parameter int          TILE_LOG2      = 5,
    parameter int          ARENA_X0       = 0,
    parameter int          ARENA_Y0       = 0,
    parameter int          COLS           = 15,
    parameter int          ROWS           = 13,
    parameter int          RANGE          = 2,
    parameter int          FUSE_CYCLES    = 200000000,
    parameter int          EXPLODE_CYCLES = 50000000,
    parameter logic [11:0] BOMB_RGB       = 12'h222,
    parameter logic [11:0] EXPL_RGB       = 12'hF80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              C,
    input  logic [9:0]        b_x,
    input  logic [9:0]        b_y,
    input  logic              game_over,
    input  logic [9:0]        v_x,
    input  logic [9:0]        v_y,
    output logic              bomb_active,
    output logic              explode_active,
    output logic [TILE_W-1:0] bomb_col,
    output logic [TILE_W-1:0] bomb_row,
    output logic              player_hit,
    output logic [11:0]       bomb_rgb,
    output logic              bomb_on,
    output logic [11:0]       explosion_rgb,
    output logic              explosion_on
);

    localparam logic [31:0] C_FUSE_LAST    = 32'(FUSE_CYCLES - 1);
    localparam logic [31:0] C_EXPLODE_LAST = 32'(EXPLODE_CYCLES - 1);
    localparam logic [9:0]  C_HALF_TILE    = 10'(1 << (TILE_LOG2 - 1));

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    bomb_state_t       r_state;
    logic [31:0]       r_cnt;
    logic [TILE_W-1:0] r_col, r_row;
    logic [TILE_W-1:0] r_left, r_right, r_up, r_down;
    logic              r_c_prev;
    logic              r_player_hit;

    bomb_state_t       w_state_next;
    logic [31:0]       w_cnt_next;
    logic [TILE_W-1:0] w_col_next, w_row_next;
    logic [TILE_W-1:0] w_left_next, w_right_next, w_up_next, w_down_next;

    // ------------------------------------------------------------------
    // Player tile: sprite top-left plus half a tile, i.e. the tile under
    // the sprite centre. 10-bit wrap, truncated to tile width.
    // ------------------------------------------------------------------
    logic [9:0]        w_px_sum, w_py_sum;
    logic [TILE_W-1:0] w_pcol, w_prow;

    assign w_px_sum = b_x - 10'(ARENA_X0) + C_HALF_TILE;
    assign w_py_sum = b_y - 10'(ARENA_Y0) + C_HALF_TILE;
    assign w_pcol   = TILE_W'(w_px_sum >> TILE_LOG2);
    assign w_prow   = TILE_W'(w_py_sum >> TILE_LOG2);

    logic w_c_rise;
    assign w_c_rise = C && !r_c_prev;

    // ------------------------------------------------------------------
    // Arm lengths for the current bomb tile; latched at detonation.
    // ------------------------------------------------------------------
    logic [TILE_W-1:0] w_arm_left, w_arm_right, w_arm_up, w_arm_down;

    blast_arm_calc #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .RANGE (RANGE)
    ) u_arms (
        .i_bomb_col (r_col),
        .i_bomb_row (r_row),
        .o_left     (w_arm_left),
        .o_right    (w_arm_right),
        .o_up       (w_arm_up),
        .o_down     (w_arm_down)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_up     <= '0;
            r_down   <= '0;
            // Reset high so a button held through reset is not an edge.
            r_c_prev <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_col    <= w_col_next;
            r_row    <= w_row_next;
            r_left   <= w_left_next;
            r_right  <= w_right_next;
            r_up     <= w_up_next;
            r_down   <= w_down_next;
            r_c_prev <= C;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_left_next  = r_left;
        w_right_next = r_right;
        w_up_next    = r_up;
        w_down_next  = r_down;

        case (r_state)
            ST_IDLE: begin
                if (w_c_rise && !game_over) begin
                    w_col_next   = w_pcol;
                    w_row_next   = w_prow;
                    w_cnt_next   = '0;
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!game_over) begin
                    if (r_cnt == C_FUSE_LAST) begin
                        w_left_next  = w_arm_left;
                        w_right_next = w_arm_right;
                        w_up_next    = w_arm_up;
                        w_down_next  = w_arm_down;
                        w_cnt_next   = '0;
                        w_state_next = ST_EXPLODING;
                    end else begin
                        w_cnt_next   = r_cnt + 32'd1;
                    end
                end
            end
            ST_EXPLODING: begin
                if (!game_over) begin
                    if (r_cnt == C_EXPLODE_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next   = r_cnt + 32'd1;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel layers (zero latency). The 11-bit differences expose pixels
    // left of / above the arena through the borrow bit.
    // ------------------------------------------------------------------
    logic [10:0] w_vx_diff, w_vy_diff;
    logic [9:0]  w_vx_tile, w_vy_tile;
    logic        w_in_arena;
    logic        w_is_exploding;

    assign w_vx_diff  = {1'b0, v_x} - 11'(ARENA_X0);
    assign w_vy_diff  = {1'b0, v_y} - 11'(ARENA_Y0);
    assign w_vx_tile  = w_vx_diff[9:0] >> TILE_LOG2;
    assign w_vy_tile  = w_vy_diff[9:0] >> TILE_LOG2;
    assign w_in_arena = !w_vx_diff[10] && !w_vy_diff[10]
                        && (w_vx_tile < 10'(COLS)) && (w_vy_tile < 10'(ROWS));

    assign w_is_exploding = (r_state == ST_EXPLODING);

    assign bomb_on = (r_state == ST_ARMED) && w_in_arena
                     && (w_vx_tile == 10'(r_col)) && (w_vy_tile == 10'(r_row));

    assign explosion_on = w_is_exploding && w_in_arena
                          && in_cross(w_vx_tile, w_vy_tile, 10'(r_col), 10'(r_row),
                                      10'(r_left), 10'(r_right), 10'(r_up), 10'(r_down));

    assign bomb_rgb      = BOMB_RGB;
    assign explosion_rgb = EXPL_RGB;

    // ------------------------------------------------------------------
    // Player hit: same cross test on the player tile, one cycle late.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_player_hit <= 1'b0;
        end else begin
            r_player_hit <= w_is_exploding
                            && in_cross(10'(w_pcol), 10'(w_prow), 10'(r_col), 10'(r_row),
                                        10'(r_left), 10'(r_right), 10'(r_up), 10'(r_down));
        end
    end

    assign player_hit     = r_player_hit;
    assign bomb_active    = (r_state == ST_ARMED);
    assign explode_active = w_is_exploding;
    assign bomb_col       = r_col;
    assign bomb_row       = r_row;

endmodule : bomb_controller
`default_nettype wire

// File: tb/tb_bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_controller
//  Description : Directed self-checking bench for bomb_controller with a
//                short fuse (10) and explosion (5) so whole bomb lifetimes
//                fit in a few dozen cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        C;
    logic [9:0]  b_x, b_y;
    logic        game_over;
    logic [9:0]  v_x, v_y;
    logic        bomb_active, explode_active, player_hit;
    logic [4:0]  bomb_col, bomb_row;
    logic [11:0] bomb_rgb, explosion_rgb;
    logic        bomb_on, explosion_on;

    int checks   = 0;
    int failures = 0;

    bomb_controller #(
        .FUSE_CYCLES    (10),
        .EXPLODE_CYCLES (5),
        .RANGE          (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .C              (C),
        .b_x            (b_x),
        .b_y            (b_y),
        .game_over      (game_over),
        .v_x            (v_x),
        .v_y            (v_y),
        .bomb_active    (bomb_active),
        .explode_active (explode_active),
        .bomb_col       (bomb_col),
        .bomb_row       (bomb_row),
        .player_hit     (player_hit),
        .bomb_rgb       (bomb_rgb),
        .bomb_on        (bomb_on),
        .explosion_rgb  (explosion_rgb),
        .explosion_on   (explosion_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input int x, input int y);
        v_x = 10'(x);
        v_y = 10'(y);
        #1;
    endtask

    task automatic place(input int x, input int y);
        b_x = 10'(x);
        b_y = 10'(y);
        C   = 1'b1;
        tick(1);
        C   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; C = 1'b0; b_x = '0; b_y = '0; game_over = 1'b0;
        v_x = '0; v_y = '0;
        tick(2);

        // ---------------- reset state ----------------
        chk("rst_bomb_active",    32'(bomb_active),    0);
        chk("rst_explode_active", 32'(explode_active), 0);
        chk("rst_bomb_col",       32'(bomb_col),       0);
        chk("rst_bomb_row",       32'(bomb_row),       0);
        chk("rst_player_hit",     32'(player_hit),     0);
        chk("rst_bomb_on",        32'(bomb_on),        0);
        chk("rst_explosion_on",   32'(explosion_on),   0);
        reset = 1'b0;
        tick(1);

        // ---------------- 1: placement and fuse ----------------
        place(64, 64);
        chk("t1_bomb_active", 32'(bomb_active), 1);
        chk("t1_bomb_col",    32'(bomb_col),    2);
        chk("t1_bomb_row",    32'(bomb_row),    2);
        pix(80, 80);
        chk("t1_bomb_on_80_80", 32'(bomb_on),  1);
        chk("t1_bomb_rgb",      32'(bomb_rgb), 32'h222);
        pix(112, 80);
        chk("t1_bomb_on_112_80", 32'(bomb_on), 0);
        tick(9);
        chk("t1_armed_at_9",     32'(bomb_active),    1);
        chk("t1_not_expl_at_9",  32'(explode_active), 0);
        tick(1);
        chk("t1_expl_at_10",     32'(explode_active), 1);
        chk("t1_bomb_off_at_10", 32'(bomb_active),    0);

        // ---------------- 2: cross shape for (2,2) ----------------
        pix(144, 80);
        chk("t2_expl_4_2",   32'(explosion_on), 1);
        chk("t2_expl_rgb",   32'(explosion_rgb), 32'hF80);
        pix(176, 80);
        chk("t2_expl_5_2",   32'(explosion_on), 0);
        pix(80, 16);
        chk("t2_expl_2_0",   32'(explosion_on), 1);
        pix(16, 80);
        chk("t2_expl_0_2",   32'(explosion_on), 1);
        pix(112, 112);
        chk("t2_expl_3_3",   32'(explosion_on), 0);

        // ---------------- 5: player hit during the (2,2) blast ----------------
        b_x = 10'd96; b_y = 10'd64;
        tick(1);
        chk("t5_hit_3_2",     32'(player_hit), 1);
        b_x = 10'd160;
        tick(1);
        chk("t5_hit_5_2",     32'(player_hit), 0);
        tick(2);
        chk("t2_expl_at_4",   32'(explode_active), 1);
        tick(1);
        chk("t2_expl_done",   32'(explode_active), 0);
        pix(80, 80);
        chk("t2_expl_on_idle", 32'(explosion_on), 0);

        // ---------------- 3: odd-row bomb (2,1) ----------------
        place(64, 32);
        chk("t3_bomb_col", 32'(bomb_col), 2);
        chk("t3_bomb_row", 32'(bomb_row), 1);
        tick(10);
        chk("t3_exploding", 32'(explode_active), 1);
        pix(112, 48);
        chk("t3_expl_3_1", 32'(explosion_on), 0);
        pix(80, 112);
        chk("t3_expl_2_3", 32'(explosion_on), 1);
        pix(80, 16);
        chk("t3_expl_2_0", 32'(explosion_on), 1);
        pix(80, 48);
        chk("t3_expl_centre", 32'(explosion_on), 1);
        tick(5);
        chk("t3_done", 32'(explode_active), 0);

        // ---------------- 4: corner bomb (0,0) ----------------
        place(0, 0);
        chk("t4_bomb_col", 32'(bomb_col), 0);
        chk("t4_bomb_row", 32'(bomb_row), 0);
        pix(16, 16);
        chk("t4_bomb_on_0_0", 32'(bomb_on), 1);
        tick(10);
        pix(80, 16);
        chk("t4_expl_2_0", 32'(explosion_on), 1);
        pix(16, 80);
        chk("t4_expl_0_2", 32'(explosion_on), 1);
        pix(112, 16);
        chk("t4_expl_3_0", 32'(explosion_on), 0);
        pix(700, 10);
        chk("t4_expl_outside", 32'(explosion_on), 0);
        tick(5);
        chk("t4_done", 32'(explode_active), 0);

        // ---------------- 6: C held across reset release ----------------
        reset = 1'b1; C = 1'b1; b_x = 10'd64; b_y = 10'd64;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("t6_held_no_place", 32'(bomb_active), 0);
        C = 1'b0;
        tick(1);
        place(64, 64);
        chk("t6_place_after_release", 32'(bomb_active), 1);
        tick(1);
        // Second press while armed must be ignored.
        place(0, 0);
        tick(1);
        chk("t6_second_col", 32'(bomb_col), 2);
        chk("t6_second_row", 32'(bomb_row), 2);
        // Reset mid-ARMED.
        reset = 1'b1;
        tick(1);
        pix(80, 80);
        chk("t6_rst_bomb_active", 32'(bomb_active), 0);
        chk("t6_rst_bomb_col",    32'(bomb_col),    0);
        chk("t6_rst_bomb_row",    32'(bomb_row),    0);
        chk("t6_rst_bomb_on",     32'(bomb_on),     0);
        reset = 1'b0;
        tick(1);

        // game_over freezes the fuse at count 4.
        place(64, 64);
        tick(4);
        game_over = 1'b1;
        tick(20);
        chk("t6_go_still_armed", 32'(bomb_active),    1);
        chk("t6_go_no_expl",     32'(explode_active), 0);
        pix(80, 80);
        chk("t6_go_bomb_on",     32'(bomb_on),        1);
        game_over = 1'b0;
        tick(5);
        chk("t6_armed_5_after",  32'(bomb_active),    1);
        tick(1);
        chk("t6_expl_6_after",   32'(explode_active), 1);
        tick(5);
        chk("t6_expl_done",      32'(explode_active), 0);

        // game_over blocks placement in IDLE.
        game_over = 1'b1;
        place(64, 64);
        chk("t6_go_blocks_place", 32'(bomb_active), 0);
        game_over = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bomb_controller
`default_nettype wire

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
Single-bomb placement, fuse and explosion engine for the arena. It sits downstream of the bomberman player module. It consumes the debounced centre button and the player position (b_x, b_y), and produces the bomb and explosion pixel layers (rgb plus enable) for the top-level priority mux. It also produces a player_hit flag that feeds game-over logic.

Parameters:
TILE_LOG2, 5, tile edge = 2^TILE_LOG2 pixels (32).
ARENA_X0, 0, arena left edge in pixels.
ARENA_Y0, 0, arena top edge in pixels.
COLS, 15, arena width in tiles.
ROWS, 13, arena height in tiles.
RANGE, 2, maximum blast arm length in tiles.
FUSE_CYCLES, 200000000, clocks from placement to detonation (2 s at 100 MHz).
EXPLODE_CYCLES, 50000000, clocks the explosion stays visible and lethal.
BOMB_RGB, 12'h222, bomb colour.
EXPL_RGB, 12'hF80, explosion colour.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
C  in  1  debounced place-bomb button (level)
b_x  in  10  player sprite top-left x, pixels
b_y  in  10  player sprite top-left y, pixels
game_over  in  1  freezes all timers while high
v_x  in  10  current VGA pixel x (hCount)
v_y  in  10  current VGA pixel y (vCount)
bomb_active  out  1  a bomb is armed
explode_active  out  1  explosion in progress
bomb_col  out  5  tile column of current bomb
bomb_row  out  5  tile row of current bomb
player_hit  out  1  player centre tile lies inside the explosion
bomb_rgb  out  12  bomb pixel colour
bomb_on  out  1  pixel (v_x,v_y) is within the bomb tile
explosion_rgb  out  12  explosion pixel colour
explosion_on  out  1  pixel (v_x,v_y) is within the explosion cross

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-high, port name `reset`.
- Reset: FSM goes to IDLE, counters 0. bomb_active, explode_active, player_hit, bomb_on and explosion_on are all 0. bomb_col and bomb_row are 0. The C edge-detect register resets to 1, so a button held through reset places nothing until it is released and pressed again.
- Player tile: pcol = (b_x - ARENA_X0 + 2^(TILE_LOG2-1)) >> TILE_LOG2, and prow is computed the same way from b_y. Use 10-bit arithmetic and truncate the result to 5 bits.
- FSM states: IDLE, ARMED, EXPLODING.
  - IDLE: on a C rising edge (C=1 and previous C=0) with game_over=0, latch bomb_col=pcol and bomb_row=prow, clear the counter, and go to ARMED. bomb_active rises the next cycle.
  - ARMED: the counter increments each cycle unless game_over=1. When the counter reaches FUSE_CYCLES-1, latch the four arm lengths, clear the counter, and go to EXPLODING.
  - EXPLODING: the counter increments the same way. When it reaches EXPLODE_CYCLES-1, go to IDLE.
  - C edges in ARMED or EXPLODING are ignored. Only one bomb exists at a time.
- Arm lengths, latched at detonation:
  - left = min(RANGE, bomb_col)
  - right = min(RANGE, COLS-1-bomb_col)
  - up = min(RANGE, bomb_row)
  - down = min(RANGE, ROWS-1-bomb_row)
  - Pillars sit at odd-col, odd-row tiles. If bomb_row is odd, left and right are forced to 0. If bomb_col is odd, up and down are forced to 0.
- Pixel layer: combinational from v_x, v_y and registered state, with zero latency so it aligns with the other sprite layers.
  - The pixel tile is (v_x-ARENA_X0)>>TILE_LOG2 by (v_y-ARENA_Y0)>>TILE_LOG2. Pixels outside the arena give bomb_on=0 and explosion_on=0.
  - bomb_on = bomb_active and pixel tile == bomb tile.
  - explosion_on = explode_active and the pixel tile is the centre tile, or lies on the bomb row within [col-left, col+right], or lies on the bomb column within [row-up, row+down].
  - bomb_rgb and explosion_rgb are the constant colours.
- player_hit: registered, 1-cycle latency. It applies the same cross test to (pcol, prow) while explode_active is 1, and is 0 otherwise.
- Reset mid-ARMED or mid-EXPLODING: state goes to IDLE on the next edge and all outputs drop.
- game_over=1: the state holds, pixel outputs continue to be driven, and new placement is blocked.

Decomposition:
- Shared package bomberman_pkg holds:
  - TILE_LOG2, COLS, ROWS
  - colour constants BOMB_RGB and EXPL_RGB
  - the 2-bit state encoding (IDLE=0, ARMED=1, EXPLODING=2)
  - a tile-coordinate width constant (5)
- One sub-module, blast_arm_calc: combinational. It takes bomb_col and bomb_row and produces the four arm lengths (clamped to the border, pillar-masked). It is instantiated once.

Test Plan:
Use FUSE_CYCLES=10, EXPLODE_CYCLES=5, RANGE=2 and all other defaults.
1. b_x=64, b_y=64, pulse C → next cycle bomb_active=1, bomb_col=2, bomb_row=2. Pixel (80,80) gives bomb_on=1. 10 cycles later explode_active=1, bomb_active=0.
2. Bomb at (2,2) while exploding → pixel (144,80) (tile 4,2) gives explosion_on=1. Pixel (176,80) (tile 5,2) gives 0. Pixel (80,16) (tile 2,0) gives 1. After 5 cycles explode_active=0.
3. b_x=64, b_y=32 (tile 2,1, odd row) → during the explosion, tile (3,1) gives explosion_on=0 and tile (2,3) gives 1.
4. b_x=0, b_y=0 (tile 0,0) → left and up arms are 0. Tile (2,0) is lit, tile (0,2) is lit, and pixel (700,10) gives explosion_on=0.
5. Player moves to b_x=96, b_y=64 (tile 3,2) during explosion of the (2,2) bomb → player_hit=1 one cycle later. Moving to tile (5,2) gives player_hit=0.
6. C held high across a reset release → no placement. Second C pulse while ARMED → bomb_col and bomb_row unchanged. Assert reset mid-ARMED → all outputs 0 next cycle. game_over=1 at counter 4 → counter frozen for 20 cycles, then detonation occurs 6 cycles after game_over drops.
